// File: rtl/stopwatch_lap_ctrl_if.sv
// Button/lock inputs and counter/display control outputs of the stopwatch sequencer.
// The master side is the button/lock source; the slave side is the sequencer.
interface stopwatch_lap_ctrl_if #(
  parameter int LAP_W = 4
);
  logic             STRTSTOP;
  logic             LAPRST;
  logic             locked;
  logic             CNT_EN;
  logic             CNT_RST;
  logic             DISP_HOLD;
  logic             LAP_LOAD;
  logic [LAP_W-1:0] LAP_NUM;
  logic             RUNNING;
  logic             FAULT;

  modport master (
    output STRTSTOP, LAPRST, locked,
    input  CNT_EN, CNT_RST, DISP_HOLD, LAP_LOAD, LAP_NUM, RUNNING, FAULT
  );

  modport slave (
    input  STRTSTOP, LAPRST, locked,
    output CNT_EN, CNT_RST, DISP_HOLD, LAP_LOAD, LAP_NUM, RUNNING, FAULT
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencer: turns start/stop and lap/clear pulses plus DCM lock into
// counter clear, tick enable, lap capture and display hold. All outputs registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CLEAR    | issue one CNT_RST, zero laps/fault/prescaler, go to ZERO
// ZERO     | time is zero, waiting for start
// RUN      | counting, display live
// LAP_HOLD | counting, display frozen on the captured lap
// STOPPED  | counting paused, prescaler keeps its partial tick
module stopwatch_lap_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int PRE_W    = 20,
  parameter int LAP_W    = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  stopwatch_lap_ctrl_if.slave  bus
);

  localparam logic [2:0] S_CLEAR    = 3'd0;
  localparam logic [2:0] S_ZERO     = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_LAP_HOLD = 3'd3;
  localparam logic [2:0] S_STOPPED  = 3'd4;

  localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(TICK_DIV - 1);
  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             disp_hold_q, disp_hold_d;
  logic             lap_load_q, lap_load_d;
  logic [LAP_W-1:0] lap_num_q, lap_num_d;
  logic             running_q, running_d;
  logic             fault_q, fault_d;
  logic             run_next;

  // Next state, lap bookkeeping and prescaler advance from current state and inputs.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_en_d   = 1'b0;
    cnt_rst_d  = 1'b0;
    lap_load_d = 1'b0;
    lap_num_d  = lap_num_q;
    fault_d    = fault_q;

    case (state_q)
      S_CLEAR: begin
        state_d   = S_ZERO;
        cnt_rst_d = 1'b1;
        lap_num_d = '0;
        fault_d   = 1'b0;
        pre_d     = '0;
      end
      S_ZERO: begin
        if (bus.STRTSTOP && bus.locked) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.locked) begin
          state_d = S_STOPPED;
          fault_d = 1'b1;
        end else if (bus.STRTSTOP) begin
          state_d = S_STOPPED;
        end else if (bus.LAPRST) begin
          state_d    = S_LAP_HOLD;
          lap_load_d = 1'b1;
          if (lap_num_q != LAP_MAX) begin
            lap_num_d = lap_num_q + LAP_W'(1);
          end
        end
      end
      S_LAP_HOLD: begin
        if (!bus.locked) begin
          state_d = S_STOPPED;
          fault_d = 1'b1;
        end else if (bus.STRTSTOP) begin
          state_d = S_STOPPED;
        end else if (bus.LAPRST) begin
          state_d = S_RUN;
        end
      end
      S_STOPPED: begin
        // A start with the DCM unlocked is dropped, and it also swallows a same-edge clear.
        if (bus.STRTSTOP && bus.locked) begin
          state_d = S_RUN;
        end else if (bus.LAPRST && !bus.STRTSTOP) begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    run_next = (state_d == S_RUN) || (state_d == S_LAP_HOLD);

    // Prescaler only moves while the next state counts, so a pause keeps the partial tick.
    if (run_next) begin
      if (pre_q == PRE_TC) begin
        pre_d    = '0;
        cnt_en_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    running_d   = run_next;
    disp_hold_d = (state_d == S_LAP_HOLD);
  end

  // State and registered outputs; RESET forces everything low without waiting for an edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_CLEAR;
      pre_q       <= '0;
      cnt_en_q    <= 1'b0;
      cnt_rst_q   <= 1'b0;
      disp_hold_q <= 1'b0;
      lap_load_q  <= 1'b0;
      lap_num_q   <= '0;
      running_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_en_q    <= cnt_en_d;
      cnt_rst_q   <= cnt_rst_d;
      disp_hold_q <= disp_hold_d;
      lap_load_q  <= lap_load_d;
      lap_num_q   <= lap_num_d;
      running_q   <= running_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.CNT_EN    = cnt_en_q;
  assign bus.CNT_RST   = cnt_rst_q;
  assign bus.DISP_HOLD = disp_hold_q;
  assign bus.LAP_LOAD  = lap_load_q;
  assign bus.LAP_NUM   = lap_num_q;
  assign bus.RUNNING   = running_q;
  assign bus.FAULT     = fault_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: fixed vector table, corner sequences and random
// stimulus against a reference model based on elapsed running edges and lap totals.
module tb_stopwatch_lap_ctrl;
  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;
  localparam int LAP_W    = 2;

  localparam int M_CLEAR = 0;
  localparam int M_ZERO  = 1;
  localparam int M_RUN   = 2;
  localparam int M_LAP   = 3;
  localparam int M_STOP  = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  // Free-running 100 MHz-style clock.
  always #5 CLK = ~CLK;

  stopwatch_lap_ctrl_if #(.LAP_W(LAP_W)) sw_if ();

  stopwatch_lap_ctrl #(
    .TICK_DIV(TICK_DIV),
    .PRE_W   (PRE_W),
    .LAP_W   (LAP_W)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (sw_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode, total running edges since the last clear, total laps taken.
  int         m_mode;
  int         m_ticks;
  int         m_laps;
  bit         m_fault;
  logic [7:0] m_out;

  typedef struct {
    bit         ss;
    bit         lr;
    bit         lk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[21];

  // Output order: CNT_EN CNT_RST DISP_HOLD LAP_LOAD RUNNING FAULT LAP_NUM[1:0]
  function automatic logic [7:0] dut_outs();
    return {sw_if.CNT_EN, sw_if.CNT_RST, sw_if.DISP_HOLD, sw_if.LAP_LOAD,
            sw_if.RUNNING, sw_if.FAULT, sw_if.LAP_NUM};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (en rst hold load run fault lap) at %0t",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode  = M_CLEAR;
    m_ticks = 0;
    m_laps  = 0;
    m_fault = 1'b0;
    m_out   = 8'h00;
  endtask

  task automatic model_step(input bit ss, input bit lr, input bit lk);
    bit e_rst;
    bit e_load;
    bit e_en;
    bit counting;
    int shown;
    e_rst  = 1'b0;
    e_load = 1'b0;
    e_en   = 1'b0;
    case (m_mode)
      M_CLEAR: begin
        m_mode  = M_ZERO;
        e_rst   = 1'b1;
        m_laps  = 0;
        m_fault = 1'b0;
        m_ticks = 0;
      end
      M_ZERO: if (ss && lk) m_mode = M_RUN;
      M_RUN, M_LAP: begin
        if (!lk) begin
          m_fault = 1'b1;
          m_mode  = M_STOP;
        end else if (ss) begin
          m_mode = M_STOP;
        end else if (lr) begin
          if (m_mode == M_RUN) begin
            e_load = 1'b1;
            m_laps++;
            m_mode = M_LAP;
          end else begin
            m_mode = M_RUN;
          end
        end
      end
      default: begin
        if (ss && lk) m_mode = M_RUN;
        else if (lr && !ss) m_mode = M_CLEAR;
      end
    endcase
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    if (counting) begin
      m_ticks++;
      e_en = (m_ticks % TICK_DIV) == 0;
    end
    shown = (m_laps > 3) ? 3 : m_laps;
    m_out = {e_en, e_rst, (m_mode == M_LAP), e_load, counting, m_fault, 2'(shown)};
  endtask

  task automatic step(input bit ss, input bit lr, input bit lk, input string name);
    sw_if.STRTSTOP = ss;
    sw_if.LAPRST   = lr;
    sw_if.locked   = lk;
    @(posedge CLK);
    #1;
    model_step(ss, lr, lk);
    check(name, dut_outs(), m_out);
    sw_if.STRTSTOP = 1'b0;
    sw_if.LAPRST   = 1'b0;
  endtask

  // Main sequence: table, corner cases, random run, summary.
  initial begin
    bit got_en;
    vecs[0]  = '{0, 0, 1, 8'b0100_0000};
    vecs[1]  = '{0, 1, 1, 8'b0000_0000};
    vecs[2]  = '{0, 0, 1, 8'b0000_0000};
    vecs[3]  = '{1, 0, 1, 8'b0000_1000};
    vecs[4]  = '{0, 0, 1, 8'b0000_1000};
    vecs[5]  = '{0, 0, 1, 8'b0000_1000};
    vecs[6]  = '{0, 0, 1, 8'b1000_1000};
    vecs[7]  = '{0, 1, 1, 8'b0011_1001};
    vecs[8]  = '{0, 0, 1, 8'b0010_1001};
    vecs[9]  = '{0, 0, 1, 8'b0010_1001};
    vecs[10] = '{0, 0, 1, 8'b1010_1001};
    vecs[11] = '{0, 1, 1, 8'b0000_1001};
    vecs[12] = '{1, 1, 1, 8'b0000_0001};
    vecs[13] = '{0, 0, 0, 8'b0000_0001};
    vecs[14] = '{1, 0, 0, 8'b0000_0001};
    vecs[15] = '{1, 0, 1, 8'b0000_1001};
    vecs[16] = '{0, 0, 0, 8'b0000_0101};
    vecs[17] = '{1, 0, 1, 8'b0000_1101};
    vecs[18] = '{1, 0, 1, 8'b0000_0101};
    vecs[19] = '{0, 1, 1, 8'b0000_0101};
    vecs[20] = '{0, 0, 1, 8'b0100_0000};

    sw_if.STRTSTOP = 1'b0;
    sw_if.LAPRST   = 1'b0;
    sw_if.locked   = 1'b1;
    RESET          = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", dut_outs(), 8'h00);
    RESET = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].ss, vecs[i].lr, vecs[i].lk, $sformatf("model_vec%0d", i));
      check($sformatf("table_vec%0d", i), dut_outs(), vecs[i].exp);
    end

    // Lap index saturates at 3 while the 5th lap still pulses LAP_LOAD.
    step(1, 0, 1, "sat_start");
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, $sformatf("sat_lap%0d", k));
      check($sformatf("sat_load%0d", k), {7'b0, sw_if.LAP_LOAD}, 8'd1);
      if (k == 4) check("sat_lap_num", {6'b0, sw_if.LAP_NUM}, 8'd3);
      step(0, 1, 1, $sformatf("sat_unlap%0d", k));
    end

    // Stop two edges after a tick, idle, restart: next tick two edges after restart.
    got_en = 1'b0;
    for (int i = 0; i < 8 && !got_en; i++) begin
      step(0, 0, 1, "wait_en");
      got_en = sw_if.CNT_EN;
    end
    check("en_seen", {7'b0, got_en}, 8'd1);
    step(0, 0, 1, "post_en");
    step(1, 0, 1, "hold_stop");
    for (int i = 0; i < 10; i++) step(0, 0, 1, "hold_idle");
    step(1, 0, 1, "hold_restart");
    check("hold_en_r0", {7'b0, sw_if.CNT_EN}, 8'd0);
    step(0, 0, 1, "hold_r1");
    check("hold_en_r1", {7'b0, sw_if.CNT_EN}, 8'd0);
    step(0, 0, 1, "hold_r2");
    check("hold_en_r2", {7'b0, sw_if.CNT_EN}, 8'd1);

    // Asynchronous reset from LAP_HOLD clears outputs before any edge.
    step(0, 1, 1, "lap_before_reset");
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", dut_outs(), 8'h00);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step(0, 0, 1, "post_reset_clear");
    check("post_reset_rst", {7'b0, sw_if.CNT_RST}, 8'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) != 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
